// File: rtl/btb_param_pkg.sv
// Shared types and default sizes for the parametrised branch target buffer.
package btb_param_pkg;

  localparam int unsigned BTB_ENTRIES             = 8;
  localparam int unsigned BITS_SATURATION_COUNTER = 2;
  localparam int unsigned BTB_TAG_BITS            = 8;

  // Resolved branch coming back from EX.
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] target_address;
    logic        is_mispredict;
    logic        is_taken;
    logic        is_lower_16;
    logic        valid;
    logic        clear;
  } branchpredict_t;

  // Prediction hint attached to the fetch entry.
  typedef struct packed {
    logic        valid;
    logic [63:0] predict_address;
    logic        predict_taken;
    logic        is_lower_16;
  } branchpredict_sbe_t;

endpackage

// File: rtl/btb_param_if.sv
// Fetch-side lookup and EX-side update signals of the branch target buffer.
interface btb_param_if;
  import btb_param_pkg::*;

  logic               flush_i;
  logic [63:0]        vpc_i;
  branchpredict_t     branch_predict_i;
  branchpredict_sbe_t branch_predict_o;

  modport master (
    output flush_i, vpc_i, branch_predict_i,
    input  branch_predict_o
  );

  modport slave (
    input  flush_i, vpc_i, branch_predict_i,
    output branch_predict_o
  );
endinterface

// File: rtl/btb_param_sat_counter_upd.sv
// Next-state logic of a B-bit saturating direction counter; alloc loads weakly taken.
module btb_param_sat_counter_upd #(
  parameter int unsigned B = 2
) (
  input  logic [B-1:0] counter,
  input  logic         taken,
  input  logic         alloc,
  output logic [B-1:0] counter_nxt
);

  always_comb begin
    counter_nxt = counter;
    if (alloc) begin
      counter_nxt        = '0;
      counter_nxt[B-1]   = 1'b1;
    end else if (taken) begin
      if (counter != '1) counter_nxt = counter + 1'b1;
    end else begin
      if (counter != '0) counter_nxt = counter - 1'b1;
    end
  end

endmodule

// File: rtl/btb_param.sv
// Flop-based branch target buffer: combinational lookup, registered update.
// Optional tag compare enabled by defining BTB_TAG_EN.
module btb_param #(
  parameter int unsigned NR_ENTRIES              = btb_param_pkg::BTB_ENTRIES,
  parameter int unsigned BITS_SATURATION_COUNTER = btb_param_pkg::BITS_SATURATION_COUNTER,
  parameter int unsigned TAG_BITS                = btb_param_pkg::BTB_TAG_BITS
) (
  input logic        clk_i,
  input logic        rst_i,
  btb_param_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NR_ENTRIES);
  localparam int unsigned B    = BITS_SATURATION_COUNTER;

  typedef struct packed {
    logic                valid;
    logic [B-1:0]        counter;
    logic [63:0]         target;
    logic                is_lower_16;
`ifdef BTB_TAG_EN
    logic [TAG_BITS-1:0] tag;
`endif
  } btb_entry_t;

  btb_entry_t      table_q [NR_ENTRIES];
  btb_entry_t      lk_e, up_e;
  logic [IdxW-1:0] lk_idx, up_idx;
  logic            lk_hit, up_hit;
  logic            up_alloc, up_write;
  logic [B-1:0]    cnt_nxt;

  assign lk_idx = bus.vpc_i[2 +: IdxW];
  assign up_idx = bus.branch_predict_i.pc[2 +: IdxW];

  always_comb begin
    lk_e   = table_q[lk_idx];
    up_e   = table_q[up_idx];
`ifdef BTB_TAG_EN
    lk_hit = lk_e.valid && (lk_e.tag == bus.vpc_i[2+IdxW +: TAG_BITS]);
    up_hit = up_e.valid && (up_e.tag == bus.branch_predict_i.pc[2+IdxW +: TAG_BITS]);
`else
    lk_hit = lk_e.valid;
    up_hit = up_e.valid;
`endif
  end

  always_comb begin
    bus.branch_predict_o = '0;
    if (lk_hit) begin
      bus.branch_predict_o.valid           = 1'b1;
      bus.branch_predict_o.predict_taken   = lk_e.counter[B-1];
      bus.branch_predict_o.predict_address = lk_e.target;
      bus.branch_predict_o.is_lower_16     = lk_e.is_lower_16;
    end
  end

  // A miss only allocates when taken; a tag mismatch counts as a miss.
  assign up_alloc = !up_hit && bus.branch_predict_i.is_taken;
  assign up_write = up_hit || bus.branch_predict_i.is_taken;

  btb_param_sat_counter_upd #(
    .B (B)
  ) u_sat_counter_upd (
    .counter     (up_e.counter),
    .taken       (bus.branch_predict_i.is_taken),
    .alloc       (up_alloc),
    .counter_nxt (cnt_nxt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NR_ENTRIES); i++) table_q[i] <= '0;
    end else if (bus.flush_i) begin
      for (int i = 0; i < int'(NR_ENTRIES); i++) table_q[i].valid <= 1'b0;
    end else if (bus.branch_predict_i.valid) begin
      if (bus.branch_predict_i.clear) begin
        table_q[up_idx].valid <= 1'b0;
      end else if (up_write) begin
        table_q[up_idx].valid   <= 1'b1;
        table_q[up_idx].counter <= cnt_nxt;
        if (bus.branch_predict_i.is_taken) begin
          table_q[up_idx].target      <= bus.branch_predict_i.target_address;
          table_q[up_idx].is_lower_16 <= bus.branch_predict_i.is_lower_16;
`ifdef BTB_TAG_EN
          table_q[up_idx].tag         <= bus.branch_predict_i.pc[2+IdxW +: TAG_BITS];
`endif
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{bus.vpc_i, bus.branch_predict_i.pc, bus.branch_predict_i.is_mispredict};

`ifndef BTB_TAG_EN
  logic [TAG_BITS-1:0] unused_tag;
  assign unused_tag = '0;
`endif

endmodule

// File: tb/tb_btb_param.sv
// Directed bench for btb_param (NR_ENTRIES=8, 2-bit counters).
module tb_btb_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  btb_param_if bus ();

  btb_param #(
    .NR_ENTRIES              (8),
    .BITS_SATURATION_COUNTER (2),
    .TAG_BITS                (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [63:0] pc, input logic [63:0] tgt, input logic taken,
                     input logic lower, input logic clr);
    bus.branch_predict_i.pc             = pc;
    bus.branch_predict_i.target_address = tgt;
    bus.branch_predict_i.is_taken       = taken;
    bus.branch_predict_i.is_mispredict  = 1'b0;
    bus.branch_predict_i.is_lower_16    = lower;
    bus.branch_predict_i.clear          = clr;
    bus.branch_predict_i.valid          = 1'b1;
    tick();
    bus.branch_predict_i.valid = 1'b0;
    bus.branch_predict_i.clear = 1'b0;
  endtask

  task automatic look(input logic [63:0] pc);
    bus.vpc_i = pc;
    #1;
  endtask

  initial begin
    bus.flush_i          = 1'b0;
    bus.vpc_i            = '0;
    bus.branch_predict_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    look(64'h80);
    check("rst_valid", 64'(bus.branch_predict_o.valid), 64'd0);
    check("rst_taken", 64'(bus.branch_predict_o.predict_taken), 64'd0);
    check("rst_addr", bus.branch_predict_o.predict_address, 64'h0);

    upd(64'h80, 64'h200, 1'b1, 1'b0, 1'b0);
    look(64'h80);
    check("alloc_valid", 64'(bus.branch_predict_o.valid), 64'd1);
    check("alloc_taken", 64'(bus.branch_predict_o.predict_taken), 64'd1);
    check("alloc_addr", bus.branch_predict_o.predict_address, 64'h200);

    // Counter 2 -> 3 -> 3 -> 3, then down 2, 1, 0, 0.
    repeat (3) upd(64'h80, 64'h200, 1'b1, 1'b0, 1'b0);
    look(64'h80);
    check("sat_hi_taken", 64'(bus.branch_predict_o.predict_taken), 64'd1);
    upd(64'h80, 64'h777, 1'b0, 1'b0, 1'b0);
    check("nt1_taken", 64'(bus.branch_predict_o.predict_taken), 64'd1);
    check("nt1_addr_kept", bus.branch_predict_o.predict_address, 64'h200);
    upd(64'h80, 64'h777, 1'b0, 1'b0, 1'b0);
    check("nt2_taken", 64'(bus.branch_predict_o.predict_taken), 64'd0);
    upd(64'h80, 64'h777, 1'b0, 1'b0, 1'b0);
    upd(64'h80, 64'h777, 1'b0, 1'b0, 1'b0);
    check("nt4_valid", 64'(bus.branch_predict_o.valid), 64'd1);
    check("nt4_taken", 64'(bus.branch_predict_o.predict_taken), 64'd0);
    // From 0, one taken gives 1 (still not taken); a wrap would show up here.
    upd(64'h80, 64'h300, 1'b1, 1'b0, 1'b0);
    check("sat_lo_taken", 64'(bus.branch_predict_o.predict_taken), 64'd0);
    check("retarget_addr", bus.branch_predict_o.predict_address, 64'h300);
    upd(64'h80, 64'h300, 1'b1, 1'b0, 1'b0);
    check("up_to2_taken", 64'(bus.branch_predict_o.predict_taken), 64'd1);

    // Same-cycle lookup and update: lookup sees the old contents.
    bus.branch_predict_i.pc             = 64'h80;
    bus.branch_predict_i.target_address = 64'h999;
    bus.branch_predict_i.is_taken       = 1'b0;
    bus.branch_predict_i.valid          = 1'b1;
    #1;
    check("same_cyc_taken", 64'(bus.branch_predict_o.predict_taken), 64'd1);
    tick();
    bus.branch_predict_i.valid = 1'b0;
    check("after_same_taken", 64'(bus.branch_predict_o.predict_taken), 64'd0);
    check("after_same_addr", bus.branch_predict_o.predict_address, 64'h300);

    // Flush together with an update: flush wins.
    upd(64'h84, 64'h400, 1'b1, 1'b0, 1'b0);
    bus.flush_i = 1'b1;
    upd(64'h88, 64'h500, 1'b1, 1'b0, 1'b0);
    bus.flush_i = 1'b0;
    look(64'h80);
    check("flush_80", 64'(bus.branch_predict_o.valid), 64'd0);
    look(64'h84);
    check("flush_84", 64'(bus.branch_predict_o.valid), 64'd0);
    look(64'h88);
    check("flush_88_dropped", 64'(bus.branch_predict_o.valid), 64'd0);

    // Clear and no-allocate-on-not-taken.
    upd(64'h80, 64'h200, 1'b1, 1'b1, 1'b0);
    look(64'h80);
    check("realloc_valid", 64'(bus.branch_predict_o.valid), 64'd1);
    check("realloc_lower16", 64'(bus.branch_predict_o.is_lower_16), 64'd1);
    upd(64'h80, 64'h0, 1'b1, 1'b0, 1'b1);
    check("clear_valid", 64'(bus.branch_predict_o.valid), 64'd0);
    check("clear_addr", bus.branch_predict_o.predict_address, 64'h0);
    upd(64'h84, 64'h400, 1'b0, 1'b0, 1'b0);
    look(64'h84);
    check("nt_no_alloc", 64'(bus.branch_predict_o.valid), 64'd0);

    // Asynchronous reset mid-run, then an update right after release.
    upd(64'h84, 64'h400, 1'b1, 1'b0, 1'b0);
    check("pre_rst_valid", 64'(bus.branch_predict_o.valid), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(bus.branch_predict_o.valid), 64'd0);
    rst = 1'b0;
    upd(64'h84, 64'h600, 1'b1, 1'b0, 1'b0);
    check("post_rst_valid", 64'(bus.branch_predict_o.valid), 64'd1);
    check("post_rst_addr", bus.branch_predict_o.predict_address, 64'h600);

    // Aliasing: 0x80 and 0xA0 share index 0.
    upd(64'h80, 64'h200, 1'b1, 1'b0, 1'b0);
    look(64'hA0);
`ifdef BTB_TAG_EN
    check("alias_valid", 64'(bus.branch_predict_o.valid), 64'd0);
    check("alias_addr", bus.branch_predict_o.predict_address, 64'h0);
`else
    check("alias_valid", 64'(bus.branch_predict_o.valid), 64'd1);
    check("alias_addr", bus.branch_predict_o.predict_address, 64'h200);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
